// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: arbitrates one writer and one reader onto an SRAM wrapper.
// A write takes one WR cycle. A read is one RD_ISSUE cycle followed by
// RD_WAIT, which collects two mem_ry beats or gives up after TIMEOUT cycles.
module sram_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req,
    input  logic [7:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_gnt,
    input  logic        rd_req,
    input  logic [7:0]  rd_addr,
    output logic        rd_gnt,
    output logic        rd_valid,
    output logic [8:0]  rd_data,
    output logic        rd_last,
    output logic        mem_we_n,
    output logic        mem_read_n,
    output logic [7:0]  mem_w_addr,
    output logic [7:0]  mem_r_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ry,
    input  logic [8:0]  mem_data,
    output logic        busy,
    output logic        timeout_err,
    input  logic        err_clr
);

    typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_WAIT} state_t;

    // Count value seen in the last RD_WAIT cycle we are willing to spend.
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_rd_q, last_rd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        beat_q, beat_d;
    logic        terr_q, terr_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [7:0]  rd_addr_q, rd_addr_d;

    // State register: all control and capture flops, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_rd_q <= 1'b1;
            cnt_q     <= '0;
            beat_q    <= 1'b0;
            terr_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            terr_q    <= terr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Next-state: arbitration, request capture, beat counting and timeout.
    always_comb begin
        logic pick_wr;
        logic timeout_hit;
        // NOTE: hold-by-default assignments keep this block free of latches.
        state_d     = state_q;
        last_rd_d   = last_rd_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;
        pick_wr     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the side that was not served last wins.
                pick_wr = wr_req && (!rd_req || last_rd_q);
                if (pick_wr) begin
                    state_d   = WR;
                    last_rd_d = 1'b0;
                    wr_addr_d = wr_addr;
                    wr_data_d = wr_data;
                end else if (rd_req) begin
                    state_d   = RD_ISSUE;
                    last_rd_d = 1'b1;
                    rd_addr_d = rd_addr;
                end
            end
            WR: state_d = IDLE;
            RD_ISSUE: begin
                state_d = RD_WAIT;
                cnt_d   = '0;
                beat_d  = 1'b0;
            end
            RD_WAIT: begin
                if (mem_ry && beat_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (mem_ry) beat_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A timeout in the same cycle as err_clr leaves the flag set.
        terr_d = (terr_q && !err_clr) || timeout_hit;
    end

    // Outputs: decoded from state; read beats pass mem_data straight through.
    always_comb begin
        busy        = (state_q != IDLE);
        wr_gnt      = (state_q == WR);
        mem_we_n    = (state_q != WR);
        rd_gnt      = (state_q == RD_ISSUE);
        mem_read_n  = (state_q != RD_ISSUE);
        rd_valid    = (state_q == RD_WAIT) && mem_ry;
        rd_last     = rd_valid && beat_q;
        rd_data     = mem_data;
        mem_w_addr  = wr_addr_q;
        mem_wdata   = wr_data_q;
        mem_r_addr  = rd_addr_q;
        timeout_err = terr_q;
    end

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of RD_WAIT cycles before a read is aborted (legal range 3..15).
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port wr_req, input, 1 bit: writer request; held with wr_addr and wr_data until wr_gnt.
REQ-006 SHALL have port wr_addr, input, 8 bits: write word address.
REQ-007 SHALL have port wr_data, input, 32 bits: write word.
REQ-008 SHALL have port wr_gnt, output, 1 bit: one-cycle write accept.
REQ-009 SHALL have port rd_req, input, 1 bit: reader request; held with rd_addr until rd_gnt.
REQ-010 SHALL have port rd_addr, input, 8 bits: read word address.
REQ-011 SHALL have port rd_gnt, output, 1 bit: one-cycle read accept.
REQ-012 SHALL have ports rd_valid (output, 1 bit), rd_data (output, 9 bits) and rd_last (output, 1 bit): read beat strobe, beat data, and second-beat marker.
REQ-013 SHALL have ports mem_we_n (output, 1), mem_read_n (output, 1), mem_w_addr (output, 8), mem_r_addr (output, 8), mem_wdata (output, 32): the SRAM wrapper controls.
REQ-014 SHALL have ports mem_ry (input, 1) and mem_data (input, 9): the SRAM wrapper ready strobe and 9-bit beat.
REQ-015 SHALL have ports busy (output, 1) = state != IDLE; timeout_err (output, 1), sticky; err_clr (input, 1) clears timeout_err.

Function
REQ-016 SHALL implement the states IDLE, WR, RD_ISSUE and RD_WAIT.
REQ-017 IDLE: when wr_req only, the next state SHALL be WR; when rd_req only, RD_ISSUE; when both, the requester not served last (last_rd flag); when neither, IDLE.
REQ-018 On leaving IDLE, the controller SHALL capture addr/data into registers and update last_rd (1 = read).
REQ-019 WR SHALL last exactly 1 cycle: mem_we_n=0, mem_w_addr and mem_wdata from capture, wr_gnt=1; next state IDLE.
REQ-020 RD_ISSUE SHALL last exactly 1 cycle: mem_read_n=0, mem_r_addr from capture, rd_gnt=1; next state RD_WAIT.
REQ-021 RD_WAIT: each cycle with mem_ry=1 SHALL produce rd_valid=1 and rd_data=mem_data (combinational pass-through); rd_last=1 on the second beat; the state SHALL return to IDLE after the second beat.
REQ-022 The RD_WAIT cycle counter (4 bits) SHALL clear on entry; if it reaches TIMEOUT before the second beat, the state SHALL go to IDLE and timeout_err SHALL be set; rd_last SHALL not be issued.
REQ-023 mem_ry SHALL be ignored outside RD_WAIT; rd_valid SHALL be 0 outside RD_WAIT.
REQ-024 Outside WR, mem_we_n SHALL be 1; outside RD_ISSUE, mem_read_n SHALL be 1; the two SHALL never be low together.
REQ-025 Throughput SHALL be 1 write per 2 cycles; a read SHALL take 2 + RD_WAIT cycles, with no idle bubble beyond the single IDLE cycle.
REQ-026 If err_clr and a timeout occur in the same cycle, set SHALL win.
REQ-027 A request dropped before grant SHALL not be issued.

Reset
REQ-028 While rst=1, asynchronously: state=IDLE, last_rd=1 (write wins the first tie), counter=0, timeout_err=0, mem_we_n=1, mem_read_n=1, grants/rd_valid/rd_last=0, address/data registers=0.
REQ-029 A reset during WR or RD_WAIT SHALL abort the transfer immediately, with no grant or beat afterwards.

Verification
REQ-030 Write: wr_req, wr_addr=0x12, wr_data=0xDEADBEEF -> the next cycle has mem_we_n=0, mem_w_addr=0x12, mem_wdata=0xDEADBEEF, wr_gnt=1.
REQ-031 Read: rd_addr=0x05, and the memory model returns ry on the 2nd and 3rd cycles after issue with 0x1AB then 0x055 -> rd_valid twice, rd_data 0x1AB then 0x055, with rd_last only on 0x055.
REQ-032 Contention: wr_req and rd_req both held continuously after reset -> grant order W,R,W,R; mem_we_n and mem_read_n never low together.
REQ-033 Timeout: read issued, mem_ry held 0 -> after 15 RD_WAIT cycles, timeout_err=1 and state IDLE; err_clr pulse -> timeout_err=0.
REQ-034 Reset mid-read: assert rst in RD_WAIT -> mem_read_n=1 and busy=0 with no clock edge; no rd_valid after reset.
REQ-035 Stray ry: mem_ry=1 while IDLE -> rd_valid stays 0.
